// File: rtl/phase2speed_sched_pkg.sv
// Shared types and constants for the phase2speed round-robin scheduler.
package p2s_sched_pkg;

   // Scheduler sequence: grant, start pulse, latency wait, result hold.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int NCH_DEF     = 4;
   localparam int PHASE_W_DEF = 19;
   localparam int SPEED_W_DEF = 16;
   localparam int N_W_DEF     = 8;
   localparam int LAT_DEF     = 20;

   // Index width that never collapses to zero bits (NCH = 1 still needs a wire).
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

   localparam int CH_W = clog2_min1(NCH_DEF);

endpackage

// File: rtl/phase2speed_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
module rr_arbiter
   import p2s_sched_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CW  = clog2_min1(NCH)
)(
   input  logic [NCH-1:0] req,
   input  logic [CW-1:0]  ptr,
   output logic [NCH-1:0] grant,
   output logic [CW-1:0]  idx,
   output logic           any
);

   // Walk the channels starting at ptr; the first hit wins and masks later ones.
   always_comb begin
      logic [CW-1:0] cand_s;
      logic          hit_s;
      grant  = '0;
      idx    = '0;
      any    = 1'b0;
      cand_s = '0;
      hit_s  = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         cand_s        = CW'((int'(ptr) + i) % NCH);
         hit_s         = req[cand_s] & ~any;
         grant[cand_s] = grant[cand_s] | hit_s;
         idx           = hit_s ? cand_s : idx;
         any           = any | hit_s;
      end
   end

endmodule

// File: rtl/phase2speed_sched.sv
// Round-robin scheduler sharing one phase2speed converter among NCH channels.
// Each job: grant in IDLE, one-cycle start pulse, fixed LAT wait, result held
// until accepted. Optional per-channel result counters: define P2S_CHCNT_EN.
module phase2speed_sched
   import p2s_sched_pkg::*;
#(
   parameter int NCH     = 4,
   parameter int PHASE_W = 19,
   parameter int SPEED_W = 16,
   parameter int N_W     = 8,
   parameter int LAT     = 20,
   localparam int CHW    = clog2_min1(NCH),
   localparam int CNT_W  = clog2_min1(LAT)
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cfg_en,
   input  logic [N_W-1:0]         cfg_n,
   input  logic [NCH-1:0]         req_valid,
   input  logic [NCH*PHASE_W-1:0] req_phase,
   output logic [NCH-1:0]         req_ready,
   output logic                   p2s_data_rdy,
   output logic [PHASE_W-1:0]     p2s_in_phasediff,
   output logic [N_W-1:0]         p2s_n,
   input  logic [SPEED_W-1:0]     p2s_out_speed,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [CHW-1:0]         res_ch,
   output logic [SPEED_W-1:0]     res_speed,
   output logic                   busy
`ifdef P2S_CHCNT_EN
   ,output logic [NCH*16-1:0]     ch_cnt
`else
`endif
);

   state_t               state_r;
   state_t               next_s;
   logic [CHW-1:0]       rr_ptr_r;
   logic [CHW-1:0]       ch_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [NCH-1:0]       grant_s;
   logic [CHW-1:0]       grant_idx_s;
   logic                 grant_any_s;
   logic                 start_s;
   logic                 last_s;
   logic                 hs_s;
   logic [PHASE_W-1:0]   phase_sel_s;

   rr_arbiter #(.NCH(NCH), .CW(CHW)) u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr_r),
      .grant (grant_s),
      .idx   (grant_idx_s),
      .any   (grant_any_s)
   );

   assign start_s = (state_r == IDLE) & cfg_en & grant_any_s;
   assign last_s  = (state_r == WAIT) & (cnt_r == '0);
   assign hs_s    = res_valid & res_ready;

   // Grant is visible only in the IDLE cycle that wins, and never during reset.
   always_comb begin
      req_ready = '0;
      if (start_s && !reset) begin
         req_ready = grant_s;
      end else begin
         req_ready = '0;
      end
   end

   // One-hot mux of the granted channel's phase word.
   always_comb begin
      phase_sel_s = '0;
      for (int i = 0; i < NCH; i++) begin
         phase_sel_s = phase_sel_s | ({PHASE_W{grant_s[i]}} & req_phase[i*PHASE_W +: PHASE_W]);
      end
   end

   // Next-state decode for the job sequence.
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_s) next_s = ISSUE;
            else         next_s = IDLE;
         end
         ISSUE: next_s = WAIT;
         WAIT: begin
            if (last_s) next_s = DONE;
            else        next_s = WAIT;
         end
         DONE: begin
            if (hs_s) next_s = IDLE;
            else      next_s = DONE;
         end
         default: next_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= IDLE;
      else       state_r <= next_s;
   end

   // Grant capture: start pulse, held converter inputs, channel and pointer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p2s_data_rdy     <= 1'b0;
         p2s_in_phasediff <= '0;
         p2s_n            <= '0;
         ch_r             <= '0;
         rr_ptr_r         <= '0;
      end else begin
         p2s_data_rdy <= start_s;
         if (start_s) begin
            p2s_in_phasediff <= phase_sel_s;
            p2s_n            <= cfg_n;
            ch_r             <= grant_idx_s;
            rr_ptr_r         <= (grant_idx_s == CHW'(NCH-1)) ? '0 : grant_idx_s + CHW'(1);
         end
      end
   end

   // Conversion latency counter: loaded in ISSUE, counts down through WAIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                  cnt_r <= '0;
      else if (state_r == ISSUE)                  cnt_r <= CNT_W'(LAT-1);
      else if (state_r == WAIT && cnt_r != '0)    cnt_r <= cnt_r - CNT_W'(1);
      else                                        cnt_r <= cnt_r;
   end

   // Result register: captured on the last wait cycle, held until accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_valid <= 1'b0;
         res_ch    <= '0;
         res_speed <= '0;
      end else if (last_s) begin
         res_valid <= 1'b1;
         res_ch    <= ch_r;
         res_speed <= p2s_out_speed;
      end else if (hs_s) begin
         res_valid <= 1'b0;
      end
   end

   // Busy tracks every non-IDLE state: set on grant, cleared on result handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          busy <= 1'b0;
      else if (start_s)                   busy <= 1'b1;
      else if (state_r == DONE && hs_s)   busy <= 1'b0;
   end

`ifdef P2S_CHCNT_EN
   // Per-channel delivered-result counters, wrapping at 16 bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ch_cnt <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (hs_s && (res_ch == CHW'(i))) ch_cnt[i*16 +: 16] <= ch_cnt[i*16 +: 16] + 16'd1;
         end
      end
   end
`else
`endif

endmodule

// File: tb/tb_phase2speed_sched.sv
// Scoreboard bench for phase2speed_sched with a fixed-latency converter stub.
module tb_phase2speed_sched;

   localparam int LAT = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_en;
   logic [7:0]  cfg_n;
   logic [3:0]  req_valid;
   logic [75:0] req_phase;
   logic [3:0]  req_ready;
   logic        p2s_data_rdy;
   logic [18:0] p2s_in_phasediff;
   logic [7:0]  p2s_n;
   logic [15:0] p2s_out_speed;
   logic        res_valid;
   logic        res_ready;
   logic [1:0]  res_ch;
   logic [15:0] res_speed;
   logic        busy;
`ifdef P2S_CHCNT_EN
   logic [63:0] ch_cnt;
`endif

   phase2speed_sched #(.NCH(4), .PHASE_W(19), .SPEED_W(16), .N_W(8), .LAT(LAT)) dut (
      .clk              (clk),
      .reset            (reset),
      .cfg_en           (cfg_en),
      .cfg_n            (cfg_n),
      .req_valid        (req_valid),
      .req_phase        (req_phase),
      .req_ready        (req_ready),
      .p2s_data_rdy     (p2s_data_rdy),
      .p2s_in_phasediff (p2s_in_phasediff),
      .p2s_n            (p2s_n),
      .p2s_out_speed    (p2s_out_speed),
      .res_valid        (res_valid),
      .res_ready        (res_ready),
      .res_ch           (res_ch),
      .res_speed        (res_speed),
      .busy             (busy)
`ifdef P2S_CHCNT_EN
      ,.ch_cnt          (ch_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Converter stub: result = phase[15:0] ^ 16'h1634, valid only LAT cycles after the pulse.
   int          stub_k = 0;
   logic [18:0] stub_phase = 19'd0;
   always @(posedge clk) begin
      if (p2s_data_rdy) begin
         stub_k     <= 1;
         stub_phase <= p2s_in_phasediff;
      end else if (stub_k != 0 && stub_k < LAT) begin
         stub_k <= stub_k + 1;
      end else begin
         stub_k <= 0;
      end
   end
   assign p2s_out_speed = (stub_k == LAT) ? (stub_phase[15:0] ^ 16'h1634) : 16'hDEAD;

   int total  = 0;
   int passed = 0;

   logic [26:0] iss_q[$];   // {phase, n}
   logic [17:0] res_q[$];   // {ch, speed}
   bit          spacing_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: pops expectations whenever the DUT issues a job or delivers a result.
   initial begin : monitor
      logic        prev_rdy;
      logic        prev_stall;
      logic [1:0]  prev_ch;
      logic [15:0] prev_speed;
      bit          have_last;
      int          last_cyc;
      logic [26:0] ei;
      logic [17:0] er;
      prev_rdy = 1'b0; prev_stall = 1'b0; prev_ch = 2'd0; prev_speed = 16'd0;
      have_last = 1'b0; last_cyc = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_rdy = 1'b0; prev_stall = 1'b0; have_last = 1'b0;
         end else begin
            if (p2s_data_rdy) begin
               check("rdy_single_cycle", {63'd0, prev_rdy}, 64'd0);
               if (iss_q.size() == 0) begin
                  check("unexpected_issue", 64'd1, 64'd0);
               end else begin
                  ei = iss_q.pop_front();
                  check("issue_phase", {45'd0, p2s_in_phasediff}, {45'd0, ei[26:8]});
                  check("issue_n", {56'd0, p2s_n}, {56'd0, ei[7:0]});
               end
               if (spacing_en && have_last) check("rdy_spacing", 64'(cyc - last_cyc), 64'd23);
               last_cyc  = cyc;
               have_last = spacing_en;
            end
            if (res_valid && prev_stall) begin
               check("stall_ch_stable", {62'd0, res_ch}, {62'd0, prev_ch});
               check("stall_speed_stable", {48'd0, res_speed}, {48'd0, prev_speed});
            end
            if (res_valid && res_ready) begin
               if (res_q.size() == 0) begin
                  check("unexpected_result", 64'd1, 64'd0);
               end else begin
                  er = res_q.pop_front();
                  check("res_ch", {62'd0, res_ch}, {62'd0, er[17:16]});
                  check("res_speed", {48'd0, res_speed}, {48'd0, er[15:0]});
               end
            end
            prev_rdy   = p2s_data_rdy;
            prev_stall = res_valid & ~res_ready;
            prev_ch    = res_ch;
            prev_speed = res_speed;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_res_valid(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (res_valid) ok = 1'b1;
      end
      check(name, {63'd0, ok}, 64'd1);
   endtask

   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (!busy && iss_q.size() == 0 && res_q.size() == 0) ok = 1'b1;
      end
      check(name, {63'd0, ok}, 64'd1);
   endtask

   initial begin : stim
      int  t0;
      bit  seen;
      reset     = 1'b1;
      cfg_en    = 1'b1;
      cfg_n     = 8'd8;
      req_valid = 4'b0000;
      req_phase = {19'h7FFFF, 19'h4ABCD, 19'h01111, 19'h00400};
      res_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_rdy", {63'd0, p2s_data_rdy}, 64'd0);
      check("rst_res_valid", {63'd0, res_valid}, 64'd0);
      check("rst_req_ready", {60'd0, req_ready}, 64'd0);
      check("rst_phase", {45'd0, p2s_in_phasediff}, 64'd0);
      check("rst_n", {56'd0, p2s_n}, 64'd0);
      check("rst_res", {46'd0, res_ch, res_speed}, 64'd0);
      step(); reset = 1'b0;
      step();

      // Single request on ch0
      iss_q.push_back({19'h00400, 8'd8});
      res_q.push_back({2'd0, 16'h1234});
      req_valid = 4'b0001;
      @(negedge clk);
      check("t1_grant", {60'd0, req_ready}, 64'h1);
      t0 = cyc;
      step();
      @(negedge clk);
      check("t1_rdy_pulse", {63'd0, p2s_data_rdy}, 64'd1);
      check("t1_ready_drop", {60'd0, req_ready}, 64'd0);
      step(); req_valid = 4'b0000;
      wait_res_valid("t1_res_seen");
      check("t1_latency", 64'(cyc - t0), 64'd22);
      wait_idle("t1_idle");

      // Round-robin continues from ch1, then reset mid-WAIT
      step();
      iss_q.push_back({19'h01111, 8'd8});
      req_valid = 4'b0011;
      @(negedge clk);
      check("rr_grant_ch1", {60'd0, req_ready}, 64'h2);
      step(); req_valid = 4'b0000;
      repeat (5) step();
      req_valid = 4'b1111;
      reset = 1'b1;
      #1;
      check("mid_rst_busy", {63'd0, busy}, 64'd0);
      check("mid_rst_req_ready", {60'd0, req_ready}, 64'd0);
      check("mid_rst_res", {45'd0, res_valid, res_ch, res_speed}, 64'd0);
      check("mid_rst_p2s", {36'd0, p2s_data_rdy, p2s_in_phasediff, p2s_n}, 64'd0);

      // Fairness from ch0 after reset: 0,1,2,3,0,1 at 23-cycle spacing
      iss_q.push_back({19'h00400, 8'd8}); res_q.push_back({2'd0, 16'h1234});
      iss_q.push_back({19'h01111, 8'd8}); res_q.push_back({2'd1, 16'h0725});
      iss_q.push_back({19'h4ABCD, 8'd8}); res_q.push_back({2'd2, 16'hBDF9});
      iss_q.push_back({19'h7FFFF, 8'd8}); res_q.push_back({2'd3, 16'hE9CB});
      iss_q.push_back({19'h00400, 8'd8}); res_q.push_back({2'd0, 16'h1234});
      iss_q.push_back({19'h01111, 8'd8}); res_q.push_back({2'd1, 16'h0725});
      spacing_en = 1'b1;
      step(); step(); reset = 1'b0;
      @(negedge clk);
      check("post_rst_grant_ch0", {60'd0, req_ready}, 64'h1);
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (iss_q.size() == 0) seen = 1'b1;
      end
      check("fair_all_issued", {63'd0, seen}, 64'd1);
      step(); req_valid = 4'b0000;
      wait_idle("fair_idle");
      spacing_en = 1'b0;

      // Backpressure: ch2 result held 5 extra cycles while ch3 waits
      step();
      res_ready = 1'b0;
      iss_q.push_back({19'h4ABCD, 8'd8}); res_q.push_back({2'd2, 16'hBDF9});
      iss_q.push_back({19'h7FFFF, 8'd8}); res_q.push_back({2'd3, 16'hE9CB});
      req_valid = 4'b1100;
      @(negedge clk);
      check("bp_grant_ch2", {60'd0, req_ready}, 64'h4);
      wait_res_valid("bp_res_seen");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_valid", {63'd0, res_valid}, 64'd1);
         check("bp_no_grant", {60'd0, req_ready}, 64'd0);
         check("bp_no_rdy", {63'd0, p2s_data_rdy}, 64'd0);
      end
      step(); res_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (req_ready == 4'b1000) seen = 1'b1;
      end
      check("bp_grant_ch3", {63'd0, seen}, 64'd1);
      step(); req_valid = 4'b0000;
      wait_idle("bp_idle");

      // Gating: cfg_en dropped mid-WAIT; job still finishes, no grant until re-enabled
      step();
      iss_q.push_back({19'h00400, 8'd8}); res_q.push_back({2'd0, 16'h1234});
      req_valid = 4'b0001;
      @(negedge clk);
      check("gate_grant", {60'd0, req_ready}, 64'h1);
      repeat (6) step();
      cfg_en = 1'b0;
      cfg_n  = 8'hFF;
      wait_idle("gate_job_done");
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("gate_no_grant", {59'd0, busy, req_ready}, 64'd0);
      end
      step();
      iss_q.push_back({19'h00400, 8'hFF}); res_q.push_back({2'd0, 16'h1234});
      cfg_en = 1'b1;
      @(negedge clk);
      check("gate_regrant", {60'd0, req_ready}, 64'h1);
      step(); req_valid = 4'b0000;
      wait_idle("gate_idle");

`ifdef P2S_CHCNT_EN
      // Counters were cleared by the mid-job reset: ch0 x4, ch1 x2, ch2 x2, ch3 x2 since.
      check("cnt_ch0", {48'd0, ch_cnt[15:0]},  64'd4);
      check("cnt_ch1", {48'd0, ch_cnt[31:16]}, 64'd2);
      check("cnt_ch2", {48'd0, ch_cnt[47:32]}, 64'd2);
      check("cnt_ch3", {48'd0, ch_cnt[63:48]}, 64'd2);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/phase2speed_sched.md
Name: phase2speed_sched

Overview:
Round-robin scheduler that shares one phase2speed converter between NCH phase-difference sources, e.g. one per USBL hydrophone pair. It accepts a 19-bit phase difference from a requesting channel and drives it into the converter with a single-cycle data_rdy pulse. After a fixed conversion latency it captures out_speed and returns the result tagged with the channel index. It also supplies the converter's N configuration, latched once per conversion.

Parameters:
NCH, 4, number of requesting channels (2..8)
PHASE_W, 19, phase-difference width (matches phase2speed in_phasediff)
SPEED_W, 16, speed width (matches phase2speed out_speed)
N_W, 8, width of the N configuration value
LAT, 20, cycles from p2s_data_rdy to a valid p2s_out_speed (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cfg_en  in  1  1 = new grants allowed; 0 = finish in-flight job, then idle
cfg_n  in  N_W  N value forwarded to the converter, latched at grant
req_valid  in  NCH  per-channel request
req_phase  in  NCH*PHASE_W  packed phase differences; channel i = bits [i*PHASE_W +: PHASE_W]
req_ready  out  NCH  one-hot grant; handshake completes when req_valid[i] & req_ready[i]
p2s_data_rdy  out  1  single-cycle start pulse to the converter
p2s_in_phasediff  out  PHASE_W  phase value held for the converter
p2s_n  out  N_W  N value held for the converter
p2s_out_speed  in  SPEED_W  converter result
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_ch  out  clog2(NCH)  channel tag of the result
res_speed  out  SPEED_W  captured speed
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=0, all outputs 0, including p2s_data_rdy, req_ready, res_valid, p2s_in_phasediff, p2s_n, res_ch, res_speed and busy.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE (cycle t):
  - If cfg_en=1 and any req_valid is set, grant the first valid channel searching upward from rr_ptr with wrap-around.
  - req_ready is combinational and one-hot for the granted channel in this cycle only; it is 0 in every other state.
  - At the clock edge, latch req_phase[ch], cfg_n and ch; set rr_ptr=(ch+1) mod NCH; go to ISSUE.
  - If no request is pending or cfg_en=0, stay in IDLE.
- ISSUE (cycle t+1): p2s_data_rdy=1 for exactly this cycle. p2s_in_phasediff and p2s_n hold their latched values from here until the next grant. Load wait counter=LAT-1; go to WAIT.
- WAIT (cycles t+2 .. t+1+LAT): decrement the counter each cycle. In the cycle the counter reaches 0, register res_speed<=p2s_out_speed and res_ch<=ch, then go to DONE.
- DONE (from cycle t+2+LAT): res_valid=1; res_ch and res_speed stay stable until res_valid & res_ready, then go to IDLE. res_valid is registered and drops the cycle after the handshake.
- Throughput: with res_ready tied high, p2s_data_rdy pulses are exactly LAT+3 cycles apart. The converter never receives overlapping jobs.
- A channel that deasserts req_valid before it is granted is simply skipped; no state is kept per channel.
- Inputs are don't-care outside their sampling cycle:
  - cfg_n changes while busy do not affect the job in flight.
  - cfg_en=0 mid-job: the job completes normally, including DONE.
- Reset mid-job (any state) aborts immediately. No result is produced and no p2s_data_rdy is emitted after reset release until a new grant.
- NCH=1 degenerates to a pass-through sequencer with rr_ptr constant at 0.

Optional Feature:
Macro P2S_CHCNT_EN.
- Defined: adds output ch_cnt [NCH*16-1:0], one 16-bit counter per channel. A channel's counter increments on each res_valid & res_ready handshake for that channel and wraps from 0xFFFF to 0. Reset clears all counters to 0.
- Undefined: the port and the counters are absent; all other behaviour is identical.

Decomposition:
- Package p2s_sched_pkg:
  - state enum (IDLE, ISSUE, WAIT, DONE);
  - localparam CH_W=clog2(NCH);
  - default widths PHASE_W=19, SPEED_W=16.
- One sub-module, rr_arbiter (NCH): inputs req and ptr, outputs a one-hot grant and its encoded index; purely combinational.
- FSM, latency counter and result register live in the top module.

Test Plan:
- Single request: ch0 valid with 19'h00400, cfg_n=8, LAT=20, converter stub returns 16'h1234 -> req_ready[0] high in cycle t; p2s_data_rdy one cycle at t+1 with p2s_in_phasediff=19'h00400 and p2s_n=8; res_valid at t+22 with res_ch=0 and res_speed=16'h1234.
- Fairness: all 4 channels held valid, res_ready=1 -> grant order 0,1,2,3,0,1; p2s_data_rdy spacing exactly 23 cycles.
- Backpressure: res_ready low for 5 cycles in DONE -> res_valid, res_ch and res_speed stable; no new req_ready or p2s_data_rdy until the handshake.
- Gating: cfg_en dropped during WAIT -> current result still delivered, then no grant while cfg_en=0; the first grant follows the cycle cfg_en returns to 1.
- Reset mid-WAIT: reset pulse for 2 cycles -> all outputs 0 immediately, no res_valid; the next grant comes from ch0.
- P2S_CHCNT_EN: 3 results on ch2 and 1 on ch0 -> ch_cnt slice 2 = 3, slice 0 = 1, others 0. Preload slice 2 to 0xFFFF, complete one ch2 result -> slice 2 wraps to 0.
